// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  localparam int N_ITER = 32;
  localparam int CNT_W  = 6;

  // Ripple increment of the iteration counter, built without an adder.
  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] r;
    logic             c;
    c = 1'b1;
    for (int i = 0; i < CNT_W; i++) begin
      r[i] = v[i] ^ c;
      c    = v[i] & c;
    end
    return r;
  endfunction

endpackage

// File: rtl/rca32.sv
// 32-bit gate-level ripple-carry adder.
// Ports: a, b (addends), cin (carry in) -> sum, cout (carry out),
//        ovf (signed overflow).
module rca32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout,
  output logic        ovf
);

  logic [32:0] c;

  assign c[0] = cin;

  // One full adder per bit; carry ripples from bit 0 upward.
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[32];
  assign ovf  = c[32] ^ c[31];

endmodule

// File: rtl/seq_mult32.sv
// Sequential 32x32 unsigned shift-add multiplier, 32 iterations per product,
// reusing a single rca32 every cycle.
// Ports: clk, rst (sync, active-high), start, a, b (operands, latched on
//        accepted start) -> busy (iterating), done (1-cycle pulse),
//        product ({hi, lo}, valid while done and held in IDLE).
module seq_mult32
  import mult_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] product
);

  mult_state_t      state;
  logic [31:0]      mcand;
  logic [31:0]      hi;
  logic [31:0]      lo;
  logic [CNT_W-1:0] cnt;

  logic [31:0]      add_sum;
  logic             add_cout;
  logic             add_ovf_unused;

  // Sole arithmetic resource: partial-product accumulate hi + mcand.
  rca32 u_rca32 (
    .a    (hi),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout),
    .ovf  (add_ovf_unused)
  );

  // Status flags decode straight from the state register.
  assign busy    = (state == RUN);
  assign done    = (state == DONE);
  assign product = {hi, lo};

  // FSM plus datapath; operands load on an accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= a;
            lo    <= b;
            hi    <= '0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          // Carry-out becomes the new hi[31] so full-scale products survive.
          if (lo[0]) begin
            hi <= {add_cout, add_sum[31:1]};
            lo <= {add_sum[0], lo[31:1]};
          end else begin
            hi <= {1'b0, hi[31:1]};
            lo <= {hi[0], lo[31:1]};
          end
          cnt <= inc_cnt(cnt);
          if (cnt == CNT_W'(N_ITER - 1)) begin
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
